// File: rtl/execute_unit.sv
// Execute stage: operand forwarding, 16-bit ALU with {N,Z,C,V} flags and the memory-stage register.
// Define EXECUTE_MUL_EN to build the multi-cycle shift-add MUL (op 8); otherwise op 8 yields 0.
module execute_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        wre_execute,
  input  logic        write_memory_enable_execute,
  input  logic [1:0]  select_writeback_data_mux_execute,
  input  logic [3:0]  aluOp_execute,
  input  logic [15:0] srcA_in,
  input  logic [15:0] srcB_in,
  input  logic [3:0]  rs1_execute,
  input  logic [3:0]  rs2_execute,
  input  logic [3:0]  rd_execute,
  input  logic        wre_writeback,
  input  logic [3:0]  rd_writeback,
  input  logic [15:0] result_writeback,
  output logic        stall,
  output logic        wre_memory,
  output logic        write_memory_enable_memory,
  output logic [1:0]  select_writeback_data_mux_memory,
  output logic [3:0]  rd_memory,
  output logic [15:0] alu_result_memory,
  output logic [15:0] store_data_memory,
  output logic [3:0]  flags_memory
);

  logic        wre_q, wme_q;
  logic [1:0]  sel_q;
  logic [3:0]  rd_q, flags_q;
  logic [15:0] alu_q, store_q;

  logic [15:0] op_a, op_b, res_d;
  logic [3:0]  flags_d;
  logic [16:0] sum;
  logic        c_d, v_d;

`ifdef EXECUTE_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] acc_q, mul_a_q, mul_b_q;

  assign stall = (state_q == S_BUSY) || (state_q == S_IDLE && aluOp_execute == 4'd8);
`else
  assign stall = 1'b0;
`endif

  // Memory-stage result has priority over writeback; r0 is never forwarded.
  always_comb begin
    op_a = srcA_in;
    if (wre_q && rd_q == rs1_execute && rs1_execute != '0)
      op_a = alu_q;
    else if (wre_writeback && rd_writeback == rs1_execute && rs1_execute != '0)
      op_a = result_writeback;

    op_b = srcB_in;
    if (wre_q && rd_q == rs2_execute && rs2_execute != '0)
      op_b = alu_q;
    else if (wre_writeback && rd_writeback == rs2_execute && rs2_execute != '0)
      op_b = result_writeback;
  end

  always_comb begin
    sum   = '0;
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (aluOp_execute)
      4'd0: begin
        sum   = {1'b0, op_a} + {1'b0, op_b};
        res_d = sum[15:0];
        c_d   = sum[16];
        v_d   = (op_a[15] == op_b[15]) && (res_d[15] != op_a[15]);
      end
      4'd1: begin
        sum   = {1'b0, op_a} + {1'b0, ~op_b} + 17'd1;
        res_d = sum[15:0];
        c_d   = sum[16];
        v_d   = (op_a[15] != op_b[15]) && (res_d[15] != op_a[15]);
      end
      4'd2: res_d = op_a & op_b;
      4'd3: res_d = op_a | op_b;
      4'd4: res_d = op_a ^ op_b;
      4'd5: res_d = op_a << op_b[3:0];
      4'd6: res_d = op_a >> op_b[3:0];
      4'd7: res_d = op_b;
`ifdef EXECUTE_MUL_EN
      // Only reaches the register from DONE; IDLE and BUSY are stalled into bubbles.
      4'd8: res_d = acc_q;
`endif
      4'd9: res_d = op_a;
      default: res_d = '0;
    endcase
    flags_d = {res_d[15], res_d == '0, c_d, v_d};
  end

  always_ff @(posedge clk) begin
    if (reset || stall) begin
      wre_q   <= 1'b0;
      wme_q   <= 1'b0;
      sel_q   <= '0;
      rd_q    <= '0;
      alu_q   <= '0;
      store_q <= '0;
      flags_q <= '0;
    end else begin
      wre_q   <= wre_execute;
      wme_q   <= write_memory_enable_execute;
      sel_q   <= select_writeback_data_mux_execute;
      rd_q    <= rd_execute;
      alu_q   <= res_d;
      store_q <= op_b;
      flags_q <= flags_d;
    end
  end

`ifdef EXECUTE_MUL_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (aluOp_execute == 4'd8) begin
          mul_a_q <= op_a;
          mul_b_q <= op_b;
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= S_BUSY;
        end
        S_BUSY: begin
          if (mul_b_q[0]) acc_q <= acc_q + mul_a_q;
          mul_a_q <= mul_a_q << 1;
          mul_b_q <= mul_b_q >> 1;
          cnt_q   <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
`endif

  assign wre_memory                       = wre_q;
  assign write_memory_enable_memory       = wme_q;
  assign select_writeback_data_mux_memory = sel_q;
  assign rd_memory                        = rd_q;
  assign alu_result_memory                = alu_q;
  assign store_data_memory                = store_q;
  assign flags_memory                     = flags_q;

endmodule

// File: tb/tb_execute_unit.sv
// Bench for execute_unit: directed vector table, hand sequences for forwarding/MUL/reset, random vs. model.
module tb_execute_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        wre_execute, write_memory_enable_execute;
  logic [1:0]  select_writeback_data_mux_execute;
  logic [3:0]  aluOp_execute;
  logic [15:0] srcA_in, srcB_in;
  logic [3:0]  rs1_execute, rs2_execute, rd_execute;
  logic        wre_writeback;
  logic [3:0]  rd_writeback;
  logic [15:0] result_writeback;
  logic        stall;
  logic        wre_memory, write_memory_enable_memory;
  logic [1:0]  select_writeback_data_mux_memory;
  logic [3:0]  rd_memory;
  logic [15:0] alu_result_memory, store_data_memory;
  logic [3:0]  flags_memory;

  execute_unit dut (
    .clk(clk), .reset(reset),
    .wre_execute(wre_execute), .write_memory_enable_execute(write_memory_enable_execute),
    .select_writeback_data_mux_execute(select_writeback_data_mux_execute),
    .aluOp_execute(aluOp_execute), .srcA_in(srcA_in), .srcB_in(srcB_in),
    .rs1_execute(rs1_execute), .rs2_execute(rs2_execute), .rd_execute(rd_execute),
    .wre_writeback(wre_writeback), .rd_writeback(rd_writeback), .result_writeback(result_writeback),
    .stall(stall), .wre_memory(wre_memory), .write_memory_enable_memory(write_memory_enable_memory),
    .select_writeback_data_mux_memory(select_writeback_data_mux_memory), .rd_memory(rd_memory),
    .alu_result_memory(alu_result_memory), .store_data_memory(store_data_memory),
    .flags_memory(flags_memory)
  );

  always #5 clk = ~clk;

  // {wre, wme, sel[1:0], rd[3:0], alu[15:0], store[15:0], flags[3:0]}
  logic [43:0] dut_out;
  assign dut_out = {wre_memory, write_memory_enable_memory, select_writeback_data_mux_memory,
                    rd_memory, alu_result_memory, store_data_memory, flags_memory};

  int unsigned n_vec = 0, n_bad = 0;

  // Model's view of the previous instruction now sitting in the memory stage.
  logic        m_wre = 1'b0;
  logic [3:0]  m_rd  = '0;
  logic [15:0] m_alu = '0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    logic        wre, wme;
    logic [1:0]  sel;
    logic [3:0]  rd;
    logic [15:0] res;
    logic [3:0]  fl;
  } vec_t;
  vec_t tbl[13];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [15:0] fwd(input logic [3:0] rs, input logic [15:0] src);
    if (rs != 0 && m_wre && m_rd == rs) return m_alu;
    if (rs != 0 && wre_writeback && rd_writeback == rs) return result_writeback;
    return src;
  endfunction

  // Returns {result, flags} from plain integer arithmetic.
  function automatic logic [19:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    longint ua, ub, r;
    int sa, sb;
    bit c, v;
    logic [15:0] res;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    c = 0; v = 0;
    case (op)
      0: begin r = ua + ub; c = (r > 65535); v = (sa + sb > 32767) || (sa + sb < -32768); end
      1: begin r = ua - ub; c = (ua >= ub);  v = (sa - sb > 32767) || (sa - sb < -32768); end
      2: r = ua & ub;
      3: r = ua | ub;
      4: r = ua ^ ub;
      5: r = ua << b[3:0];
      6: r = ua >> b[3:0];
      7: r = ub;
`ifdef EXECUTE_MUL_EN
      8: r = ua * ub;
`endif
      9: r = ua;
      default: r = 0;
    endcase
    res = r[15:0];
    return {res, res[15], res == 16'h0, c, v};
  endfunction

  function automatic logic [43:0] model_next();
    logic [15:0] a, b;
    logic [19:0] rf;
    a  = fwd(rs1_execute, srcA_in);
    b  = fwd(rs2_execute, srcB_in);
    rf = ref_alu(aluOp_execute, a, b);
    return {wre_execute, write_memory_enable_execute, select_writeback_data_mux_execute,
            rd_execute, rf[19:4], b, rf[3:0]};
  endfunction

  task automatic set_in(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] rd,
                        input logic we, input logic me, input logic [1:0] sel);
    aluOp_execute = op; srcA_in = a; srcB_in = b;
    rs1_execute = r1; rs2_execute = r2; rd_execute = rd;
    wre_execute = we; write_memory_enable_execute = me; select_writeback_data_mux_execute = sel;
    wre_writeback = 1'b0; rd_writeback = '0; result_writeback = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string name, input logic [43:0] exp);
    chk({name, " stall"}, stall, 0);
    tick();
    chk(name, dut_out, exp);
    m_wre = exp[43]; m_rd = exp[39:36]; m_alu = exp[35:20];
  endtask

`ifdef EXECUTE_MUL_EN
  task automatic mul_run(input string name, input logic [15:0] a, input logic [15:0] b, input logic [3:0] rd);
    logic [19:0] rf;
    set_in(4'd8, a, b, 0, 0, rd, 1'b1, 1'b0, 2'd1);
    rf = ref_alu(4'd8, a, b);
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("%s stall_hi%0d", name, i), stall, 1);
      tick();
      chk($sformatf("%s bubble%0d", name, i), dut_out, 0);
    end
    chk({name, " done_stall"}, stall, 0);
    tick();
    chk(name, dut_out, {1'b1, 1'b0, 2'd1, rd, rf[19:4], b, rf[3:0]});
    m_wre = 1'b1; m_rd = rd; m_alu = rf[19:4];
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //        op  a         b         wre   wme   sel   rd     res       flags NZCV
    tbl[0]  = '{4'd0,  16'h7FFF, 16'h0001, 1'b1, 1'b0, 2'd0, 4'd1,  16'h8000, 4'b1001};
    tbl[1]  = '{4'd0,  16'hFFFF, 16'h0001, 1'b1, 1'b0, 2'd1, 4'd2,  16'h0000, 4'b0110};
    tbl[2]  = '{4'd1,  16'h0005, 16'h0010, 1'b1, 1'b0, 2'd0, 4'd3,  16'hFFF5, 4'b1000};
    tbl[3]  = '{4'd1,  16'h8000, 16'h0001, 1'b1, 1'b0, 2'd0, 4'd4,  16'h7FFF, 4'b0011};
    tbl[4]  = '{4'd2,  16'hF0F0, 16'h3C3C, 1'b1, 1'b0, 2'd0, 4'd5,  16'h3030, 4'b0000};
    tbl[5]  = '{4'd3,  16'hF0F0, 16'h0F0F, 1'b0, 1'b1, 2'd0, 4'd6,  16'hFFFF, 4'b1000};
    tbl[6]  = '{4'd4,  16'hAAAA, 16'hAAAA, 1'b1, 1'b0, 2'd2, 4'd7,  16'h0000, 4'b0100};
    tbl[7]  = '{4'd5,  16'h0001, 16'h0013, 1'b1, 1'b0, 2'd0, 4'd8,  16'h0008, 4'b0000};
    tbl[8]  = '{4'd6,  16'h8000, 16'h000F, 1'b1, 1'b0, 2'd0, 4'd9,  16'h0001, 4'b0000};
    tbl[9]  = '{4'd7,  16'h0000, 16'h1234, 1'b1, 1'b0, 2'd3, 4'd10, 16'h1234, 4'b0000};
    tbl[10] = '{4'd9,  16'hABCD, 16'h5555, 1'b1, 1'b0, 2'd0, 4'd11, 16'hABCD, 4'b1000};
    tbl[11] = '{4'd12, 16'h1234, 16'h5678, 1'b1, 1'b0, 2'd0, 4'd12, 16'h0000, 4'b0100};
    tbl[12] = '{4'd0,  16'h0002, 16'h0003, 1'b0, 1'b0, 2'd0, 4'd5,  16'h0005, 4'b0000};

    // Reset with live-looking inputs must still clear everything.
    set_in(4'd0, 16'h0005, 16'h0006, 0, 0, 4'd7, 1'b1, 1'b1, 2'd2);
    reset = 1'b1;
    tick();
    chk("reset_out", dut_out, 0);
    chk("reset_stall", stall, 0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].op, tbl[i].a, tbl[i].b, 0, 0, tbl[i].rd, tbl[i].wre, tbl[i].wme, tbl[i].sel);
      step($sformatf("tbl%0d", i),
           {tbl[i].wre, tbl[i].wme, tbl[i].sel, tbl[i].rd, tbl[i].res, tbl[i].b, tbl[i].fl});
    end

    // Memory-stage forwarding beats a conflicting writeback match.
    set_in(4'd0, 16'h0010, 16'h0000, 0, 0, 4'd3, 1'b1, 1'b0, 2'd0);
    step("fwd_prod", {1'b1, 1'b0, 2'd0, 4'd3, 16'h0010, 16'h0000, 4'b0000});
    set_in(4'd1, 16'h0005, 16'h0010, 4'd3, 0, 4'd4, 1'b1, 1'b0, 2'd0);
    wre_writeback = 1'b1; rd_writeback = 4'd3; result_writeback = 16'h7777;
    step("fwd_mem_prio", {1'b1, 1'b0, 2'd0, 4'd4, 16'h0000, 16'h0010, 4'b0110});
    set_in(4'd9, 16'h1111, 16'h0000, 4'd5, 0, 4'd6, 1'b1, 1'b0, 2'd0);
    wre_writeback = 1'b1; rd_writeback = 4'd5; result_writeback = 16'hBEEF;
    step("fwd_wb", {1'b1, 1'b0, 2'd0, 4'd6, 16'hBEEF, 16'h0000, 4'b1000});
    // r0 is never forwarded from either stage.
    set_in(4'd9, 16'h9999, 16'h0000, 0, 0, 4'd0, 1'b1, 1'b0, 2'd0);
    step("wr_r0", {1'b1, 1'b0, 2'd0, 4'd0, 16'h9999, 16'h0000, 4'b1000});
    set_in(4'd9, 16'h0004, 16'h0000, 0, 0, 4'd1, 1'b1, 1'b0, 2'd0);
    wre_writeback = 1'b1; rd_writeback = 4'd0; result_writeback = 16'hFFFF;
    step("no_fwd_r0", {1'b1, 1'b0, 2'd0, 4'd1, 16'h0004, 16'h0000, 4'b0000});

`ifdef EXECUTE_MUL_EN
    mul_run("mul_a", 16'h0123, 16'h0045, 4'd7);
    chk("mul_4e6f", alu_result_memory, 16'h4E6F);
    mul_run("mul_b2b", 16'hFFFF, 16'hFFFF, 4'd2);
    mul_run("mul_zero", 16'h1234, 16'h0000, 4'd3);

    // Reset during the 8th BUSY cycle aborts the multiply.
    set_in(4'd8, 16'h0123, 16'h0045, 0, 0, 4'd7, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("abort_stall_busy", stall, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_out", dut_out, 0);
    m_wre = 1'b0; m_rd = '0; m_alu = '0;
    set_in(4'd0, 16'h0002, 16'h0003, 0, 0, 4'd2, 1'b1, 1'b0, 2'd0);
    step("post_reset_add", {1'b1, 1'b0, 2'd0, 4'd2, 16'h0005, 16'h0003, 4'b0000});
`else
    set_in(4'd8, 16'h0123, 16'h0045, 0, 0, 4'd7, 1'b1, 1'b0, 2'd0);
    step("op8_off", {1'b1, 1'b0, 2'd0, 4'd7, 16'h0000, 16'h0045, 4'b0100});
`endif

    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
`ifdef EXECUTE_MUL_EN
      if (op == 4'd8) op = 4'd9;
`endif
      set_in(op, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 2'($urandom));
      wre_writeback    = 1'($urandom);
      rd_writeback     = 4'($urandom_range(0, 3));
      result_writeback = 16'($urandom);
      step($sformatf("rnd%0d", i), model_next());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
